score_tracker: RTL and testbench
================================

// Module: score_tracker
// PURPOSE
//  Upstream feeder of the 7-segment scoreboard. Consumes per-note judgements from
//  the rhythm-judge stage during play and accumulates combo, base score and bonus
//  score. At song end it runs a serial divider to compute accuracy and then grades
//  the level. All values are presented on stable 21-bit/3-bit buses for display.
// PARAMETERS
//  W        21    width of the combo, max_combo, base_score, bonus_score, acc and notes counter
//  PTS_PERF 300   base points for PERFECT (GREAT=2/3, GOOD=1/3 of this, MISS=0)
//  COMBO_TH 10    combo at or above which the bonus rate doubles
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous reset, active-low
//  game_start   in   1   1-cycle pulse: clear stats, enter PLAY
//  game_end     in   1   1-cycle pulse: end of song, start accuracy calc
//  hit_valid    in   1   1-cycle strobe: hit_judge is valid this cycle
//  hit_judge    in   2   0=MISS 1=GOOD 2=GREAT 3=PERFECT
//  mod          in   2   00 none, 01 hard (bonus x2), 10 easy (bonus /2), 11 none
//  difficulty   in   4   bonus weight per hit, 0..15
//  combo        out  W   current consecutive non-MISS count
//  max_combo    out  W   best combo this game
//  base_score   out  W   sum of base points
//  bonus_score  out  W   sum of combo bonus
//  acc          out  W   accuracy in 0.01% units, 0..10000
//  level        out  3   0=D 1=C 2=B 3=A 4=S 5=SS
//  busy         out  1   high while CALC runs
//  done         out  1   high in DONE: acc/level are final
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, all outputs 0, internal notes/weight counters 0.
//  - FSM: IDLE -game_start-> PLAY; PLAY -game_end-> CALC; CALC -divider finished-> DONE;
//    DONE -game_start-> PLAY. A game_start in any state clears all stats and enters PLAY
//    on the next cycle. game_start has priority over game_end and hit_valid in the same cycle.
//  - PLAY, hit_valid=1, registered the same cycle (1-cycle latency to outputs):
//    notes+=1; weight+=hit_judge (0..3); base_score+=hit_judge*PTS_PERF/3.
//    Non-MISS: combo+=1; max_combo=max(max_combo, new combo);
//      bonus step b = difficulty*(combo_new>=COMBO_TH ? 2 : 1); mod 01: b<<1, mod 10: b>>1;
//      bonus_score+=b.
//    MISS: combo=0, no bonus.
//  - All W-bit accumulators saturate at 2^W-1 and never wrap; combo saturates likewise.
//  - game_end and hit_valid in the same PLAY cycle: the hit is counted first, then CALC is entered.
//  - hit_valid outside PLAY is ignored. game_end outside PLAY is ignored.
//  - CALC: acc = (weight*10000)/(notes*3) via a restoring divider, one quotient bit per
//    cycle, fixed 2*W cycles; busy=1 throughout. notes=0 -> skip the divider, acc=0 and
//    level=0 after 1 cycle.
//  - Level is graded in the cycle CALC exits: acc=10000->5; >=9500->4; >=9000->3;
//    >=8000->2; >=7000->1; else 0. DONE is entered with done=1, busy=0.
//  - acc and level read 0 during PLAY and CALC, and hold in DONE until the next game_start.
//  - Reset mid-CALC aborts the divider and returns to IDLE with all outputs 0.
// TESTING
//  1 reset, start, 4x PERFECT, diff=2, mod=00, end -> combo=4 base=1200 bonus=8 acc=10000 level=5, done after busy
//  2 start, 10x GOOD, diff=1 -> combo=10, bonus=9*1+2=11, base=1000; then MISS -> combo=0, max_combo=10
//  3 start, PERF,MISS,GREAT,GOOD, end -> weight=6 notes=4 acc=5000 level=0
//  4 start, end with no hits -> acc=0 level=0 done within 2 cycles; mod=01 vs 10 with diff=3 single hit -> bonus 6 vs 1
//  5 hit_valid+game_end same cycle -> hit counted; game_start+hit_valid same cycle -> stats cleared, hit dropped
//  6 preload near 2^21-1 (force) then PERFECT -> base_score=2097151 held; rst_n=0 during CALC -> IDLE, outputs 0

Source files
------------

// File: rtl/score_tracker.sv
// Score tracker: accumulates combo/base/bonus during play, then runs a
// serial restoring divider for accuracy and grades the level.
module score_tracker #(
  parameter int W        = 21,
  parameter int PTS_PERF = 300,
  parameter int COMBO_TH = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         game_start,
  input  logic         game_end,
  input  logic         hit_valid,
  input  logic [1:0]   hit_judge,
  input  logic [1:0]   mod,
  input  logic [3:0]   difficulty,
  output logic [W-1:0] combo,
  output logic [W-1:0] max_combo,
  output logic [W-1:0] base_score,
  output logic [W-1:0] bonus_score,
  output logic [W-1:0] acc,
  output logic [2:0]   level,
  output logic         busy,
  output logic         done
);

  localparam int DW = 2 * W;
  localparam int IW = $clog2(DW);

  typedef enum logic [1:0] {
    S_IDLE, S_PLAY, S_CALC, S_DONE
  } state_t;

  state_t         r_state, w_state_nx;
  logic [W-1:0]   r_notes, r_weight;
  logic [IW-1:0]  r_idx;
  logic [W+1:0]   r_rem;
  logic [W-1:0]   r_quo;

  function automatic logic [W-1:0] sat_add(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? '1 : s[W-1:0];
  endfunction

  function automatic logic [2:0] grade(input logic [W-1:0] a);
    if      (a >= W'(10000)) return 3'd5;
    else if (a >= W'(9500))  return 3'd4;
    else if (a >= W'(9000))  return 3'd3;
    else if (a >= W'(8000))  return 3'd2;
    else if (a >= W'(7000))  return 3'd1;
    else                     return 3'd0;
  endfunction

  logic [W-1:0] w_pts;
  always_comb begin
    w_pts = '0;
    case (hit_judge)
      2'd1:    w_pts = W'(PTS_PERF / 3);
      2'd2:    w_pts = W'(2 * PTS_PERF / 3);
      2'd3:    w_pts = W'(PTS_PERF);
      default: w_pts = '0;
    endcase
  end

  logic [W-1:0] w_combo_nx;
  logic         w_dbl;
  logic [6:0]   w_b0, w_b;
  assign w_combo_nx = sat_add(combo, W'(1));
  assign w_dbl      = (w_combo_nx >= W'(COMBO_TH));
  assign w_b0       = {3'b0, difficulty} << w_dbl;

  always_comb begin
    w_b = w_b0;
    if (mod == 2'b01)      w_b = w_b0 << 1;
    else if (mod == 2'b10) w_b = w_b0 >> 1;
  end

  // Divider: dividend bits are consumed MSB-first straight from the product
  logic [DW-1:0] w_dvd;
  logic [W+1:0]  w_div, w_rem_sub, w_rem_nx;
  logic [W+2:0]  w_rem_sh;
  logic          w_ge, w_no_notes, w_last;
  logic [W:0]    w_q;
  logic [W-1:0]  w_acc;

  assign w_dvd      = DW'(r_weight) * DW'(10000);
  assign w_div      = {2'b0, r_notes} + {1'b0, r_notes, 1'b0};
  assign w_rem_sh   = {r_rem, w_dvd[r_idx]};
  assign w_ge       = (w_rem_sh >= {1'b0, w_div});
  assign w_rem_sub  = w_rem_sh[W+1:0] - w_div;
  assign w_rem_nx   = w_ge ? w_rem_sub : w_rem_sh[W+1:0];
  assign w_q        = {r_quo, w_ge};
  assign w_acc      = (w_q > (W+1)'(10000)) ? W'(10000)
                                            : w_q[W-1:0];
  assign w_no_notes = (r_notes == '0);
  assign w_last     = (r_idx == '0);

  always_comb begin
    w_state_nx = r_state;
    if (game_start) begin
      w_state_nx = S_PLAY;
    end else begin
      case (r_state)
        S_PLAY:  if (game_end) w_state_nx = S_CALC;
        S_CALC:  if (w_no_notes || w_last) w_state_nx = S_DONE;
        default: w_state_nx = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || r_state != S_CALC || game_start) begin
      r_idx <= IW'(DW - 1);
      r_rem <= '0;
      r_quo <= '0;
    end else begin
      r_idx <= r_idx - IW'(1);
      r_rem <= w_rem_nx;
      r_quo <= w_q[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || game_start) begin
      combo       <= '0;
      max_combo   <= '0;
      base_score  <= '0;
      bonus_score <= '0;
      acc         <= '0;
      level       <= '0;
      r_notes     <= '0;
      r_weight    <= '0;
    end else begin
      if (r_state == S_PLAY && hit_valid) begin
        r_notes    <= sat_add(r_notes, W'(1));
        r_weight   <= sat_add(r_weight, W'(hit_judge));
        base_score <= sat_add(base_score, w_pts);
        if (hit_judge != 2'd0) begin
          combo       <= w_combo_nx;
          bonus_score <= sat_add(bonus_score, W'(w_b));
          if (w_combo_nx > max_combo) max_combo <= w_combo_nx;
        end else begin
          combo <= '0;
        end
      end
      if (r_state == S_CALC) begin
        if (w_no_notes) begin
          acc   <= '0;
          level <= '0;
        end else if (w_last) begin
          acc   <= w_acc;
          level <= grade(w_acc);
        end
      end
    end
  end

  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: hand-computed scores, accuracy,
// grades, latency, priority and saturation.
module tb_score_tracker;

  localparam int W = 21;

  logic         clk = 1'b0;
  logic         rst_n, game_start, game_end, hit_valid;
  logic [1:0]   hit_judge, mod;
  logic [3:0]   difficulty;
  logic [W-1:0] combo, max_combo, base_score, bonus_score, acc;
  logic [2:0]   level;
  logic         busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  score_tracker #(.W(W), .PTS_PERF(300), .COMBO_TH(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .game_start(game_start), .game_end(game_end),
    .hit_valid(hit_valid), .hit_judge(hit_judge),
    .mod(mod), .difficulty(difficulty),
    .combo(combo), .max_combo(max_combo),
    .base_score(base_score), .bonus_score(bonus_score),
    .acc(acc), .level(level), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start;
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
  endtask

  task automatic hit(input logic [1:0] j);
    hit_valid = 1'b1;
    hit_judge = j;
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic end_game(output int n);
    game_end = 1'b1;
    tick();
    game_end = 1'b0;
    wait_done(n);
  endtask

  initial begin
    rst_n = 1'b0; game_start = 1'b0; game_end = 1'b0;
    hit_valid = 1'b0; hit_judge = 2'd0;
    mod = 2'b00; difficulty = 4'd0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_combo", combo, 0);
    chk("rst_base", base_score, 0);
    chk("rst_acc", acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    hit(2'd3);
    chk("idle_hit_ignored", base_score, 0);

    // 4x PERFECT
    difficulty = 4'd2;
    start();
    repeat (4) hit(2'd3);
    chk("t1_combo", combo, 4);
    chk("t1_base", base_score, 1200);
    chk("t1_bonus", bonus_score, 8);
    game_end = 1'b1;
    tick();
    game_end = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_acc_calc", acc, 0);
    wait_done(cyc);
    chk("t1_calc_cycles", cyc, 42);
    chk("t1_busy_done", busy, 0);
    chk("t1_acc", acc, 10000);
    chk("t1_level", level, 5);
    game_end = 1'b1;
    tick();
    game_end = 1'b0;
    chk("done_end_ignored", done, 1);
    chk("done_acc_hold", acc, 10000);

    // 10x GOOD then MISS
    difficulty = 4'd1;
    start();
    chk("t2_acc_clear", acc, 0);
    chk("t2_done_clear", done, 0);
    repeat (10) hit(2'd1);
    chk("t2_combo", combo, 10);
    chk("t2_bonus", bonus_score, 11);
    chk("t2_base", base_score, 1000);
    hit(2'd0);
    chk("t2_miss_combo", combo, 0);
    chk("t2_max", max_combo, 10);

    // mixed judgements
    start();
    hit(2'd3); hit(2'd0); hit(2'd2); hit(2'd1);
    chk("t3_max", max_combo, 2);
    end_game(cyc);
    chk("t3_acc", acc, 5000);
    chk("t3_level", level, 0);

    start();
    hit(2'd3); hit(2'd3); hit(2'd2);
    end_game(cyc);
    chk("t3b_acc", acc, 8888);
    chk("t3b_level", level, 2);

    start();
    repeat (19) hit(2'd3);
    hit(2'd2);
    end_game(cyc);
    chk("t3c_acc", acc, 9833);
    chk("t3c_level", level, 4);

    // no hits
    start();
    end_game(cyc);
    chk("t4_empty_fast", (cyc + 1 <= 2), 1);
    chk("t4_acc", acc, 0);
    chk("t4_level", level, 0);
    chk("t4_done", done, 1);

    difficulty = 4'd3;
    mod = 2'b01;
    start(); hit(2'd3);
    chk("t4_hard", bonus_score, 6);
    mod = 2'b10;
    start(); hit(2'd3);
    chk("t4_easy", bonus_score, 1);
    mod = 2'b11;
    start(); hit(2'd3);
    chk("t4_none11", bonus_score, 3);
    mod = 2'b00;
    difficulty = 4'd0;

    // same-cycle priorities
    start();
    hit_valid = 1'b1; hit_judge = 2'd3; game_end = 1'b1;
    tick();
    hit_valid = 1'b0; game_end = 1'b0;
    chk("t5_hit_end_base", base_score, 300);
    chk("t5_hit_end_busy", busy, 1);
    wait_done(cyc);
    chk("t5_hit_end_acc", acc, 10000);
    game_start = 1'b1; hit_valid = 1'b1; hit_judge = 2'd3;
    tick();
    game_start = 1'b0; hit_valid = 1'b0;
    chk("t5_start_hit_base", base_score, 0);
    chk("t5_start_hit_combo", combo, 0);
    chk("t5_start_done", done, 0);

    // saturation through play, then reset mid-CALC
    start();
    repeat (7000) hit(2'd3);
    chk("t6_base_sat", base_score, 2097151);
    hit(2'd3);
    chk("t6_base_hold", base_score, 2097151);
    chk("t6_max", max_combo, 7001);
    game_end = 1'b1;
    tick();
    game_end = 1'b0;
    repeat (5) tick();
    chk("t6_busy_mid", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_base", base_score, 0);
    chk("t6_rst_max", max_combo, 0);
    chk("t6_rst_acc", acc, 0);
    hit(2'd3);
    chk("t6_idle_hit", base_score, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
